// File: rtl/fifomult2024_tb_pkg.sv
// Shared types for the fifomult2024 operand path: frame parity status,
// transmitter FSM states and the parity-bit helper.
package fifomult2024_tb_pkg;

  typedef enum logic {
    PARITY_OK  = 1'b0,
    PARITY_ERR = 1'b1
  } paritycheck_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // 0 selects even parity: data plus parity bit holds an even number of ones.
  localparam logic PARITY_POLARITY = 1'b0;
  localparam int   PARITY_MAX_W    = 64;

  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                       input logic corrupt);
    return (^data) ^ PARITY_POLARITY ^ corrupt;
  endfunction

endpackage

// File: rtl/fifomult2024_cmd_fifo.sv
// Synchronous command FIFO with an occupancy counter, combinational read
// port and a registered full flag.
module fifomult2024_cmd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/fifomult2024_arg_tx.sv
// Operand transmitter: buffers operand pairs, attaches (optionally corrupted)
// even parity and hands frames to the multiplier over valid/ready.
module fifomult2024_arg_tx
  import fifomult2024_tb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_arg_a,
  input  logic [DATA_W-1:0] cmd_arg_b,
  input  logic              cmd_corrupt_a,
  input  logic              cmd_corrupt_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] arg_a,
  output logic [DATA_W-1:0] arg_b,
  output logic              arg_a_parity,
  output logic              arg_b_parity,
  output paritycheck_t      frame_status,
  output logic [15:0]       sent_cnt,
  output logic [15:0]       err_cnt,
  output tx_state_t         fsm_state
);

  // Handshake rule on both sides: a beat moves on a rising edge where
  // valid && ready; the producer holds payload stable while valid && !ready.

  localparam int FW = 2 * DATA_W + 2;

  tx_state_t         state;
  tx_state_t         state_next;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_wr;
  logic [FW-1:0]     fifo_rd;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              rd_ca;
  logic              rd_cb;
  logic              load;
  logic              clear_valid;
  logic              gap_load;
  logic              xfer;
  logic [3:0]        gap_cnt;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_wr   = {cmd_arg_a, cmd_arg_b, cmd_corrupt_a, cmd_corrupt_b};
  assign {rd_a, rd_b, rd_ca, rd_cb} = fifo_rd;
  assign fifo_pop  = load;
  assign xfer      = (state == SEND) && out_valid && out_ready;
  assign fsm_state = state;

  fifomult2024_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    clear_valid = 1'b0;
    gap_load    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (GAP_CYCLES == 0 && !fifo_empty) begin
            load = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            clear_valid = 1'b1;
            gap_load    = 1'b1;
            state_next  = GAP;
          end else begin
            clear_valid = 1'b1;
            state_next  = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      arg_a        <= '0;
      arg_b        <= '0;
      arg_a_parity <= 1'b0;
      arg_b_parity <= 1'b0;
      frame_status <= PARITY_OK;
      gap_cnt      <= '0;
      sent_cnt     <= '0;
      err_cnt      <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        out_valid    <= 1'b1;
        arg_a        <= rd_a;
        arg_b        <= rd_b;
        arg_a_parity <= calc_parity(PARITY_MAX_W'(rd_a), rd_ca);
        arg_b_parity <= calc_parity(PARITY_MAX_W'(rd_b), rd_cb);
        frame_status <= (rd_ca || rd_cb) ? PARITY_ERR : PARITY_OK;
      end else if (clear_valid) begin
        out_valid <= 1'b0;
      end
      if (gap_load) begin
        gap_cnt <= 4'(GAP_CYCLES);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      // Both counters saturate so long soak runs never wrap to zero.
      if (xfer) begin
        if (sent_cnt != 16'hFFFF) sent_cnt <= sent_cnt + 1'b1;
        if (frame_status == PARITY_ERR && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifomult2024_arg_tx.sv
// Bench for fifomult2024_arg_tx: one instance with no gap, one with a
// two-cycle gap, a per-instance scoreboard and one task per scenario.
module tb_fifomult2024_arg_tx;
  import fifomult2024_tb_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid, g_cmd_valid;
  logic         cmd_ready, g_cmd_ready;
  logic [15:0]  cmd_arg_a, cmd_arg_b;
  logic         cmd_corrupt_a, cmd_corrupt_b;
  logic         out_valid, g_out_valid;
  logic         out_ready, g_out_ready;
  logic [15:0]  arg_a, arg_b, g_arg_a, g_arg_b;
  logic         arg_a_parity, arg_b_parity, g_arg_a_parity, g_arg_b_parity;
  paritycheck_t frame_status, g_frame_status;
  logic [15:0]  sent_cnt, err_cnt, g_sent_cnt, g_err_cnt;
  tx_state_t    fsm_state, g_fsm_state;

  int checks;
  int passes;
  int cyc;
  int mdl_sent, mdl_err, g_mdl_sent, g_mdl_err;
  logic [34:0] exp_q[$];
  logic [34:0] gexp_q[$];
  int xfer_cyc[$];
  int g_xfer_cyc[$];

  fifomult2024_arg_tx #(.DATA_W(16), .DEPTH(4), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_arg_a(cmd_arg_a), .cmd_arg_b(cmd_arg_b),
    .cmd_corrupt_a(cmd_corrupt_a), .cmd_corrupt_b(cmd_corrupt_b),
    .out_valid(out_valid), .out_ready(out_ready), .arg_a(arg_a), .arg_b(arg_b),
    .arg_a_parity(arg_a_parity), .arg_b_parity(arg_b_parity),
    .frame_status(frame_status), .sent_cnt(sent_cnt), .err_cnt(err_cnt),
    .fsm_state(fsm_state)
  );

  fifomult2024_arg_tx #(.DATA_W(16), .DEPTH(4), .GAP_CYCLES(2)) dut_gap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready),
    .cmd_arg_a(cmd_arg_a), .cmd_arg_b(cmd_arg_b),
    .cmd_corrupt_a(cmd_corrupt_a), .cmd_corrupt_b(cmd_corrupt_b),
    .out_valid(g_out_valid), .out_ready(g_out_ready), .arg_a(g_arg_a), .arg_b(g_arg_b),
    .arg_a_parity(g_arg_a_parity), .arg_b_parity(g_arg_b_parity),
    .frame_status(g_frame_status), .sent_cnt(g_sent_cnt), .err_cnt(g_err_cnt),
    .fsm_state(g_fsm_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected frame word: {a, b, parity_a, parity_b, parity_err}
  function automatic logic [34:0] model_word(input logic [15:0] a, b, input logic ca, cb);
    return {a, b, (^a) ^ ca, (^b) ^ cb, ca | cb};
  endfunction

  task automatic push_cmd(input bit sel, input logic [15:0] a, b, input logic ca, cb);
    int guard;
    guard = 0;
    cmd_arg_a = a; cmd_arg_b = b; cmd_corrupt_a = ca; cmd_corrupt_b = cb;
    if (sel) g_cmd_valid = 1'b1; else cmd_valid = 1'b1;
    while (((sel ? g_cmd_ready : cmd_ready) == 1'b0) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 100) $display("FAIL push_timeout: cmd_ready=0 for %0d cycles, required 1", guard);
    else begin
      passes++;
      if (sel) gexp_q.push_back(model_word(a, b, ca, cb));
      else exp_q.push_back(model_word(a, b, ca, cb));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    g_cmd_valid = 1'b0;
  endtask

  task automatic run_monitor();
    logic [34:0] w;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_out: got a=%h b=%h, required no transfer", arg_a, arg_b);
        end else begin
          w = exp_q.pop_front();
          if ({arg_a, arg_b, arg_a_parity, arg_b_parity, frame_status == PARITY_ERR} !== w)
            $display("FAIL sb_out: got %h_%h_%b%b%b, required %h", arg_a, arg_b,
                     arg_a_parity, arg_b_parity, frame_status == PARITY_ERR, w);
          else passes++;
          mdl_sent++;
          mdl_err += int'(w[0]);
        end
        xfer_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic run_gap_monitor();
    logic [34:0] w;
    forever begin
      @(negedge clk);
      if (rst_n && g_out_valid && g_out_ready) begin
        checks++;
        if (gexp_q.size() == 0) begin
          $display("FAIL sb_gap_out: got a=%h b=%h, required no transfer", g_arg_a, g_arg_b);
        end else begin
          w = gexp_q.pop_front();
          if ({g_arg_a, g_arg_b, g_arg_a_parity, g_arg_b_parity, g_frame_status == PARITY_ERR} !== w)
            $display("FAIL sb_gap_out: got %h_%h_%b%b%b, required %h", g_arg_a, g_arg_b,
                     g_arg_a_parity, g_arg_b_parity, g_frame_status == PARITY_ERR, w);
          else passes++;
          g_mdl_sent++;
          g_mdl_err += int'(w[0]);
        end
        g_xfer_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if ({out_valid, arg_a, arg_b, arg_a_parity, arg_b_parity} !== 35'd0)
      $display("FAIL reset_outputs: got v=%b a=%h b=%h pa=%b pb=%b, required all 0",
               out_valid, arg_a, arg_b, arg_a_parity, arg_b_parity);
    else passes++;
    checks++;
    if (frame_status !== PARITY_OK || sent_cnt !== 16'd0 || err_cnt !== 16'd0)
      $display("FAIL reset_status: got st=%b sent=%0d err=%0d, required 0/0/0", frame_status, sent_cnt, err_cnt);
    else passes++;
    checks++;
    if (cmd_ready !== 1'b1 || g_cmd_ready !== 1'b1)
      $display("FAIL reset_cmd_ready: got %b/%b, required 1/1", cmd_ready, g_cmd_ready);
    else passes++;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || fsm_state !== IDLE)
        $display("FAIL reset_idle: got v=%b state=%0d, required 0/IDLE", out_valid, fsm_state);
      else passes++;
    end
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    push_cmd(1'b0, 16'h0003, 16'h0001, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL single_t1: got out_valid=%b, required 0", out_valid);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || arg_a_parity !== 1'b0 || arg_b_parity !== 1'b1 || frame_status !== PARITY_OK)
      $display("FAIL single_t2: got v=%b pa=%b pb=%b st=%b, required 1/0/1/0",
               out_valid, arg_a_parity, arg_b_parity, frame_status);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (sent_cnt !== 16'd1 || err_cnt !== 16'd0 || out_valid !== 1'b0)
      $display("FAIL single_cnt: got sent=%0d err=%0d v=%b, required 1/0/0", sent_cnt, err_cnt, out_valid);
    else passes++;
  endtask

  task automatic test_error_inject();
    push_cmd(1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || arg_a_parity !== 1'b1 || frame_status !== PARITY_ERR)
      $display("FAIL err_frame: got v=%b pa=%b st=%b, required 1/1/1", out_valid, arg_a_parity, frame_status);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (err_cnt !== 16'd1 || sent_cnt !== 16'd2)
      $display("FAIL err_cnt: got err=%0d sent=%0d, required 1/2", err_cnt, sent_cnt);
    else passes++;
  endtask

  task automatic test_backpressure_full();
    logic [34:0] first;
    int guard;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(1'b0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checks++;
    if (cmd_ready !== 1'b0) $display("FAIL full_cmd_ready: got %b, required 0", cmd_ready);
    else passes++;
    first = exp_q[0];
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, arg_a, arg_b, arg_a_parity, arg_b_parity, frame_status == PARITY_ERR} !== {1'b1, first})
        $display("FAIL hold_stable: got v=%b %h_%h, required 1 %h", out_valid, arg_a, arg_b, first);
      else passes++;
    end
    xfer_cyc.delete();
    out_ready = 1'b1;
    guard = 0;
    while (xfer_cyc.size() < 5 && guard < 30) begin @(posedge clk); #1; guard++; end
    checks++;
    if (xfer_cyc.size() != 5 || xfer_cyc[4] - xfer_cyc[0] != 4)
      $display("FAIL back_to_back: got %0d transfers, required 5 in consecutive cycles", xfer_cyc.size());
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (sent_cnt !== 16'(mdl_sent) || err_cnt !== 16'(mdl_err) || cmd_ready !== 1'b1)
      $display("FAIL bp_counts: got sent=%0d err=%0d rdy=%b, required %0d/%0d/1",
               sent_cnt, err_cnt, cmd_ready, mdl_sent, mdl_err);
    else passes++;
  endtask

  task automatic test_gap();
    int guard;
    g_out_ready = 1'b1;
    g_xfer_cyc.delete();
    push_cmd(1'b1, 16'h1234, 16'h00FF, 1'b0, 1'b1);
    push_cmd(1'b1, 16'hFFFF, 16'h8001, 1'b0, 1'b0);
    push_cmd(1'b1, 16'h0F0F, 16'h7000, 1'b1, 1'b1);
    guard = 0;
    while (g_xfer_cyc.size() < 3 && guard < 40) begin @(posedge clk); #1; guard++; end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (g_xfer_cyc.size() != 3 || g_xfer_cyc[i] - g_xfer_cyc[i-1] != 4)
        $display("FAIL gap_spacing: got %0d transfers / spacing mismatch at %0d, required 3 low cycles", g_xfer_cyc.size(), i);
      else passes++;
    end
    @(posedge clk); #1;
    checks++;
    if (g_sent_cnt !== 16'd3 || g_err_cnt !== 16'd2)
      $display("FAIL gap_counts: got sent=%0d err=%0d, required 3/2", g_sent_cnt, g_err_cnt);
    else passes++;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    push_cmd(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    push_cmd(1'b0, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0);
    push_cmd(1'b0, 16'h0001, 16'h0002, 1'b0, 1'b1);
    checks++;
    if (fsm_state !== SEND || out_valid !== 1'b1)
      $display("FAIL mid_pre: got state=%0d v=%b, required SEND/1", fsm_state, out_valid);
    else passes++;
    rst_n = 1'b0;
    exp_q.delete(); gexp_q.delete();
    mdl_sent = 0; mdl_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({out_valid, arg_a, arg_b, arg_a_parity, arg_b_parity, sent_cnt, err_cnt} !== 67'd0 ||
        frame_status !== PARITY_OK || cmd_ready !== 1'b1)
      $display("FAIL mid_cleared: got v=%b a=%h sent=%0d err=%0d rdy=%b, required 0/0/0/0/1",
               out_valid, arg_a, sent_cnt, err_cnt, cmd_ready);
    else passes++;
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL mid_stale: got out_valid=%b, required 0", out_valid);
      else passes++;
    end
    push_cmd(1'b0, 16'h00F0, 16'h0007, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sent_cnt !== 16'd1 || err_cnt !== 16'd0 || mdl_sent != 1)
      $display("FAIL mid_restart: got sent=%0d err=%0d seen=%0d, required 1/0/1", sent_cnt, err_cnt, mdl_sent);
    else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    mdl_sent = 0; mdl_err = 0; g_mdl_sent = 0; g_mdl_err = 0;
    cmd_valid = 1'b0; g_cmd_valid = 1'b0;
    cmd_arg_a = '0; cmd_arg_b = '0; cmd_corrupt_a = 1'b0; cmd_corrupt_b = 1'b0;
    out_ready = 1'b0; g_out_ready = 1'b0;
    fork
      run_monitor();
      run_gap_monitor();
    join_none
    test_reset();
    test_single_frame();
    test_error_inject();
    test_backpressure_full();
    test_gap();
    test_mid_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || gexp_q.size() != 0)
      $display("FAIL sb_drain: got %0d/%0d frames outstanding, required 0/0", exp_q.size(), gexp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
